// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the memory-mapped UART transmitter
package uart_pkg;
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_CNT   = 8;
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
endpackage

// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if: core data-memory bus as seen by the UART
// Signals: r read strobe, w byte-lane write strobes, addr byte address, in write data, out read data
interface uart_tx_mmio_if;
    logic        r;
    logic [3:0]  w;
    logic [31:0] addr;
    logic [31:0] in;
    logic [31:0] out;
    modport master (output r, w, addr, in, input out);
    modport slave  (input r, w, addr, in, output out);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with first-word fall-through head
// Ports: clk, rst_n (async active-low), push_i/data_i write side, pop_i/data_o read side, full_o, empty_o, count_o
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, rd_q;
    logic             do_push, do_pop;
    // the extra pointer bit tells a full wrap from empty
    assign empty_o = wr_q == rd_q;
    assign full_o  = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
    assign count_o = wr_q - rd_q;
    assign data_o  = mem_q[rd_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    always_ff @(posedge clk)
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + ONE;
            if (do_pop) rd_q <= rd_q + ONE;
        end
endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with TX FIFO
// Ports: clk, rst_n (async active-low), bus (slave: r, w, addr, in -> out, out combinational), tx (serial out, idle high)
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_mmio_if.slave bus,
    output logic          tx
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    state_e        state_q;
    logic [7:0]    shift_q, head;
    logic [2:0]    idx_q;
    logic [15:0]   cnt_q, div_q, div_d, reload;
    logic          ovf_q, ovf_d, tx_q;
    logic          hit, push, pop, clr, full, empty, bit_end;
    logic [1:0]    sel;
    logic [CW-1:0] count;
    logic [31:0]   status;
    logic          unused_bits;
    assign hit     = bus.addr[31:4] == BASE_ADDR[31:4];
    assign sel     = bus.addr[3:2];
    assign push    = hit && sel == REG_TXDATA && bus.w[0];
    assign clr     = hit && sel == REG_STATUS && bus.w[0] && bus.in[ST_OVF];
    // a divisor of 0 behaves as 1, so the countdown reload saturates at 0
    assign reload  = div_q == 16'd0 ? 16'd0 : div_q - 16'd1;
    assign bit_end = cnt_q == 16'd0;
    assign pop     = !empty && (state_q == IDLE || (state_q == STOP && bit_end));
    // a new overflow wins over a simultaneous clear
    assign ovf_d   = (push && full) || (ovf_q && !clr);
    assign div_d   = hit && sel == REG_BAUDDIV ?
                     {bus.w[1] ? bus.in[15:8] : div_q[15:8], bus.w[0] ? bus.in[7:0] : div_q[7:0]} : div_q;
    assign status  = {20'h0, 4'(count), 4'h0, ovf_q, state_q != IDLE, empty, full};
    assign bus.out = !(bus.r && hit) ? 32'h0 :
                     sel == REG_STATUS ? status :
                     sel == REG_BAUDDIV ? {16'h0, div_q} : 32'h0;
    assign tx          = tx_q;
    assign unused_bits = ^{bus.in[31:16], bus.addr[1:0]};
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (push),
        .pop_i  (pop),
        .data_i (bus.in[7:0]),
        .data_o (head),
        .full_o (full),
        .empty_o(empty),
        .count_o(count)
    );
    // every bit boundary reloads the countdown from the live divisor register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            div_q   <= DEFAULT_DIV;
            ovf_q   <= 1'b0;
        end else begin
            div_q <= div_d;
            ovf_q <= ovf_d;
            unique case (state_q)
                IDLE: if (!empty) begin
                    shift_q <= head;
                    tx_q    <= 1'b0;
                    cnt_q   <= reload;
                    state_q <= START;
                end
                START: if (bit_end) begin
                    tx_q    <= shift_q[0];
                    idx_q   <= '0;
                    cnt_q   <= reload;
                    state_q <= DATA;
                end else cnt_q <= cnt_q - 16'd1;
                DATA: if (bit_end) begin
                    cnt_q <= reload;
                    if (idx_q == 3'(DATA_BITS - 1)) begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end else begin
                        shift_q <= shift_q >> 1;
                        tx_q    <= shift_q[1];
                        idx_q   <= idx_q + 3'd1;
                    end
                end else cnt_q <= cnt_q - 16'd1;
                STOP: if (bit_end) begin
                    if (!empty) begin
                        shift_q <= head;
                        tx_q    <= 1'b0;
                        cnt_q   <= reload;
                        state_q <= START;
                    end else state_q <= IDLE;
                end else cnt_q <= cnt_q - 16'd1;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed table and sequence checks for uart_tx_mmio
module tb_uart_tx_mmio;
    localparam logic [31:0] B = 32'h0000_1000;
    typedef struct {
        string       name;
        logic [3:0]  w;
        logic [31:0] waddr, wdata;
        logic        r;
        logic [31:0] raddr, exp;
    } vec_t;
    logic clk, rst_n, tx;
    int   tests = 0, fails = 0, falls = 0;
    logic tx_prev = 1'b1;
    logic act_q [$];
    logic exp_q [$];
    vec_t vt [14];
    uart_tx_mmio_if bus ();
    uart_tx_mmio #(.BASE_ADDR(B), .FIFO_DEPTH(8), .DEFAULT_DIV(16'd16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .tx   (tx)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (tx_prev && !tx) falls <= falls + 1;
        tx_prev <= tx;
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic rd(input logic r, input logic [31:0] a, output logic [31:0] d);
        bus.r = r;
        bus.addr = a;
        #1 d = bus.out;
        bus.r = 1'b0;
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        bus.addr = a;
        bus.in = d;
        bus.w = we;
        @(negedge clk);
        bus.w = 4'h0;
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask
    task automatic add(input logic v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask
    task automatic add_frame(input logic [7:0] b, input int d);
        add(1'b0, d);
        for (int i = 0; i < 8; i++) add(b[i], d);
        add(1'b1, d);
    endtask
    task automatic capture(output int busy_n);
        logic [31:0] st;
        busy_n = 0;
        act_q.delete();
        for (int i = 0; i < exp_q.size(); i++) begin
            rd(1'b1, B + 4, st);
            act_q.push_back(tx);
            busy_n += int'(st[2]);
            @(negedge clk);
        end
    endtask
    task automatic cmp_stream(input string name);
        int bad = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && act_q[i] !== exp_q[i]) bad = i;
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL %s: sample %0d got %b expected %b", name, bad, act_q[bad], exp_q[bad]);
        end
    endtask
    initial begin
        logic [31:0] d;
        int busy_n;
        vt[0]  = '{"rst_status",    4'h0, B,         32'h0,         1'b1, B + 4,         32'h2};
        vt[1]  = '{"rst_baud",      4'h0, B,         32'h0,         1'b1, B + 8,         32'h10};
        vt[2]  = '{"txdata_read",   4'h0, B,         32'h0,         1'b1, B,             32'h0};
        vt[3]  = '{"rsvd_read",     4'h0, B,         32'h0,         1'b1, B + 12,        32'h0};
        vt[4]  = '{"r0_out",        4'h0, B,         32'h0,         1'b0, B + 4,         32'h0};
        vt[5]  = '{"lane1_nopush",  4'h2, B,         32'h0000_FFFF, 1'b1, B + 4,         32'h2};
        vt[6]  = '{"miss_nopush",   4'h1, B + 16,    32'h55,        1'b1, B + 4,         32'h2};
        vt[7]  = '{"baud_lane0",    4'h1, B + 8,     32'h1234,      1'b1, B + 8,         32'h34};
        vt[8]  = '{"baud_lane1",    4'h2, B + 8,     32'hAB00,      1'b1, B + 8,         32'hAB34};
        vt[9]  = '{"baud_both",     4'h3, B + 8,     32'hFFFF_03E8, 1'b1, B + 8,         32'h3E8};
        vt[10] = '{"baud_hi_lanes", 4'hC, B + 8,     32'h7,         1'b1, B + 8,         32'h3E8};
        vt[11] = '{"rsvd_write",    4'hF, B + 12,    32'hFFFF_FFFF, 1'b1, B + 12,        32'h0};
        vt[12] = '{"miss_read",     4'h0, B,         32'h0,         1'b1, 32'h0000_2004, 32'h0};
        vt[13] = '{"clr_no_ovf",    4'h1, B + 4,     32'h8,         1'b1, B + 4,         32'h2};
        bus.r = 1'b0;
        bus.w = 4'h0;
        bus.addr = '0;
        bus.in = '0;
        @(negedge clk);
        do_reset();
        check("rst_tx", 32'(tx), 32'h1);
        foreach (vt[i]) begin
            if (vt[i].w != 4'h0) wr(vt[i].waddr, vt[i].wdata, vt[i].w);
            rd(vt[i].r, vt[i].raddr, d);
            check(vt[i].name, d, vt[i].exp);
        end
        // single byte 0x55 at divisor 4
        do_reset();
        wr(B + 8, 32'h4, 4'h3);
        wr(B, 32'h55, 4'h1);
        exp_q.delete();
        add(1'b1, 1);
        add_frame(8'h55, 4);
        add(1'b1, 4);
        capture(busy_n);
        cmp_stream("frame_55");
        check("busy_len", 32'(busy_n), 32'd40);
        rd(1'b1, B + 4, d);
        check("status_after_55", d, 32'h2);
        // back-to-back frames at divisor 2
        do_reset();
        wr(B + 8, 32'h2, 4'h3);
        wr(B, 32'hA5, 4'h1);
        wr(B, 32'h3C, 4'h1);
        exp_q.delete();
        add_frame(8'hA5, 2);
        add_frame(8'h3C, 2);
        add(1'b1, 4);
        capture(busy_n);
        cmp_stream("back_to_back");
        // divisor raised to 8 during data bit 2 of 0x33
        do_reset();
        wr(B + 8, 32'h4, 4'h3);
        wr(B, 32'h33, 4'h1);
        exp_q.delete();
        add(1'b1, 1);
        add(1'b0, 4);
        add(1'b1, 4);
        add(1'b1, 4);
        add(1'b0, 4);
        add(1'b0, 8);
        add(1'b1, 8);
        add(1'b1, 8);
        add(1'b0, 8);
        add(1'b0, 8);
        add(1'b1, 8);
        add(1'b1, 3);
        act_q.delete();
        for (int i = 0; i < exp_q.size(); i++) begin
            act_q.push_back(tx);
            if (i == 13) begin
                bus.addr = B + 8;
                bus.in = 32'h8;
                bus.w = 4'h3;
            end
            @(negedge clk);
            bus.w = 4'h0;
        end
        cmp_stream("div_midframe");
        // overflow: one byte drains into the shifter, eight fill the FIFO, the last is dropped
        do_reset();
        begin
            int f0, c;
            f0 = falls;
            wr(B + 8, 32'h3E8, 4'h3);
            for (int i = 0; i < 10; i++) wr(B, 32'h0, 4'h1);
            rd(1'b1, B + 4, d);
            check("ovf_set", d, 32'h0000_080D);
            wr(B + 4, 32'h8, 4'h1);
            rd(1'b1, B + 4, d);
            check("ovf_clear", d, 32'h0000_0805);
            wr(B + 8, 32'h1, 4'h3);
            c = 0;
            rd(1'b1, B + 4, d);
            while (c < 5000 && d != 32'h2) begin
                @(negedge clk);
                rd(1'b1, B + 4, d);
                c++;
            end
            check("ovf_drain", d, 32'h2);
            check("ovf_frames", 32'(falls - f0), 32'd9);
        end
        // asynchronous reset during data bit 4 of 0xEF
        do_reset();
        wr(B + 8, 32'h4, 4'h3);
        wr(B, 32'hEF, 4'h1);
        repeat (22) @(negedge clk);
        check("pre_rst_bit4", 32'(tx), 32'h0);
        #2 rst_n = 1'b0;
        #1 check("async_rst_tx", 32'(tx), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        rd(1'b1, B + 4, d);
        check("post_rst_status", d, 32'h2);
        rd(1'b1, B + 8, d);
        check("post_rst_baud", d, 32'h10);
        repeat (3) @(negedge clk);
        check("post_rst_tx", 32'(tx), 32'h1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
